// File: rtl/adder_dut_pkg.sv
// Shared definitions for the sequential sliced adder.
//   adder_state_e : FSM encoding shared by the core and anything observing it
//   ADDER_WIDTH   : default operand / sum width
//   ADDER_SLICE   : default bits added per clock
//   ADDER_NSLICE  : slices per operation at the default sizes
//   ADDER_CNT_W   : slice counter width at the default sizes
package adder_dut_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } adder_state_e;

   localparam int unsigned ADDER_WIDTH  = 32;
   localparam int unsigned ADDER_SLICE  = 8;
   localparam int unsigned ADDER_NSLICE = ADDER_WIDTH / ADDER_SLICE;
   localparam int unsigned ADDER_CNT_W  = $clog2(ADDER_NSLICE);

endpackage

// File: rtl/adder_slice.sv
// Combinational SLICE-bit ripple adder, time-multiplexed by the core.
//   a, b : slice operands
//   cin  : carry into the slice
//   s    : slice sum
//   cout : carry out of the slice MSB
module adder_slice #(
   parameter int unsigned SLICE = 8
) (
   input  logic [SLICE-1:0] a,
   input  logic [SLICE-1:0] b,
   input  logic             cin,
   output logic [SLICE-1:0] s,
   output logic             cout
);

   always_comb begin
      {cout, s} = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, cin};
   end

endmodule

// File: rtl/adder_seq_core.sv
// Sequential WIDTH-bit adder computing one SLICE-bit slice per clock.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (a, b, cin)
//   out_valid/out_ready : result handshake (sum, cout, ovf)
//   sum                 : (a + b + cin) mod 2^WIDTH
//   cout                : carry out of bit WIDTH-1
//   ovf                 : two's-complement overflow of the addition
module adder_seq_core
   import adder_dut_pkg::*;
#(
   parameter int unsigned WIDTH = ADDER_WIDTH,
   parameter int unsigned SLICE = ADDER_SLICE
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int unsigned NSLICE = WIDTH / SLICE;
   localparam int unsigned CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NSLICE - 1);

   adder_state_e     state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   logic [SLICE-1:0] sl_a, sl_b, sl_s;
   logic             sl_cout;
   logic             accept;

   assign sl_a = a_q[cnt_q*SLICE +: SLICE];
   assign sl_b = b_q[cnt_q*SLICE +: SLICE];

   adder_slice #(.SLICE(SLICE)) u_slice (
      .a    (sl_a),
      .b    (sl_b),
      .cin  (carry_q),
      .s    (sl_s),
      .cout (sl_cout)
   );

   // Gated by rst_n so the core never advertises readiness while held in reset.
   assign in_ready  = rst_n &&
                      ((state_q == IDLE) || ((state_q == DONE) && out_ready));
   assign accept    = in_valid && in_ready;
   assign out_valid = (state_q == DONE);
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               a_d     = a;
               b_d     = b;
               carry_d = cin;
               cnt_d   = '0;
               state_d = BUSY;
            end
         end
         BUSY: begin
            sum_d[cnt_q*SLICE +: SLICE] = sl_s;
            carry_d = sl_cout;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == LAST_SLICE) begin
               cnt_d   = '0;
               cout_d  = sl_cout;
               // The top slice's MSB is the final sum MSB.
               ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                         (sl_s[SLICE-1] != a_q[WIDTH-1]);
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               if (in_valid) begin
                  a_d     = a;
                  b_d     = b;
                  carry_d = cin;
                  cnt_d   = '0;
                  state_d = BUSY;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

endmodule

// File: tb/tb_adder_seq_core.sv
// Directed self-checking bench for adder_seq_core.
module tb_adder_seq_core;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        cin;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] sum;
   logic        cout;
   logic        ovf;

   int n_checks = 0;
   int n_fail   = 0;

   adder_seq_core #(.WIDTH(32), .SLICE(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge, then settle 1 time unit past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Wait for out_valid, optionally scrambling operand inputs each cycle.
   task automatic wait_done(input string tag, input bit scramble, output int cyc);
      cyc = 0;
      while (!out_valid && cyc < 20) begin
         if (scramble) begin
            a   = $urandom;
            b   = $urandom;
            cin = 1'($urandom);
         end
         tick();
         cyc++;
      end
      if (!out_valid) check_eq({tag, "_timeout"}, 32'(out_valid), 32'd1);
   endtask

   // Full operation with out_ready held high; checks latency and results.
   task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                         input logic ci, input logic [31:0] es, input logic ec,
                         input logic eo);
      int cyc;
      check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      a = av; b = bv; cin = ci; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      wait_done(tag, 1'b1, cyc);
      check_eq({tag, "_latency"}, 32'(cyc), 32'd4);
      check_eq({tag, "_sum"},  sum,         es);
      check_eq({tag, "_cout"}, 32'(cout),   32'(ec));
      check_eq({tag, "_ovf"},  32'(ovf),    32'(eo));
      tick();
      check_eq({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
      check_eq({tag, "_idle_ready"}, 32'(in_ready),  32'd1);
   endtask

   initial begin
      int cyc;
      logic [31:0] held;

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; cin = 1'b0;
      #2;
      check_eq("rst_in_ready",  32'(in_ready),  32'd0);
      check_eq("rst_out_valid", 32'(out_valid), 32'd0);
      check_eq("rst_sum",       sum,            32'd0);
      check_eq("rst_cout_ovf",  {30'd0, cout, ovf}, 32'd0);
      tick(); tick();
      rst_n = 1'b1;
      #1;
      check_eq("rel_in_ready", 32'(in_ready), 32'd1);
      tick();

      // Wrap, carry out; then signed overflow cases.
      run_op("wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
      run_op("povf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
      run_op("novf", 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
      run_op("mix",  32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);

      // Back-pressure: result held for 10 cycles, new inputs ignored meanwhile.
      a = 32'h1234_5678; b = 32'h0FED_CBA9; cin = 1'b1;
      in_valid = 1'b1; out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      wait_done("stall", 1'b0, cyc);
      check_eq("stall_latency", 32'(cyc), 32'd4);
      held = 32'h2222_2222;
      for (int i = 0; i < 10; i++) begin
         a = $urandom; b = $urandom; in_valid = 1'b1;
         #1;
         check_eq("stall_valid", 32'(out_valid), 32'd1);
         check_eq("stall_ready", 32'(in_ready),  32'd0);
         check_eq("stall_sum",   sum,            held);
         check_eq("stall_flags", {30'd0, cout, ovf}, 32'd0);
         tick();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      #1;
      check_eq("stall_hs_ready", 32'(in_ready), 32'd1);
      tick();
      check_eq("stall_after_valid", 32'(out_valid), 32'd0);

      // Back-to-back: second pair accepted in the DONE cycle.
      a = 32'h0000_0005; b = 32'h0000_0003; cin = 1'b1; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      wait_done("b2b1", 1'b0, cyc);
      check_eq("b2b1_sum", sum, 32'h0000_0009);
      a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; cin = 1'b1; in_valid = 1'b1;
      #1;
      check_eq("b2b_accept_ready", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      check_eq("b2b_not_valid", 32'(out_valid), 32'd0);
      wait_done("b2b2", 1'b1, cyc);
      check_eq("b2b2_latency", 32'(cyc), 32'd4);
      check_eq("b2b2_sum",  sum,          32'hFFFF_FFFF);
      check_eq("b2b2_cout", 32'(cout),    32'd1);
      check_eq("b2b2_ovf",  32'(ovf),     32'd0);
      tick();

      // Reset mid-operation drops the result.
      a = 32'h0101_0101; b = 32'h0202_0202; cin = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick(); tick();
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
      check_eq("mid_rst_sum",   sum,            32'd0);
      check_eq("mid_rst_ready", 32'(in_ready),  32'd0);
      check_eq("mid_rst_flags", {30'd0, cout, ovf}, 32'd0);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         check_eq("mid_rst_no_result", 32'(out_valid), 32'd0);
      end
      run_op("fresh", 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/adder_seq_core.md
# adder_seq_core

Sequential 32-bit adder DUT that the adder UVM environment drives and checks. It accepts operand pairs over a valid/ready input handshake and computes the sum in 8-bit slices, one slice per clock. It presents sum, carry-out and signed overflow over a valid/ready output handshake. The adder agent drives the input side, and the scoreboard observes both sides.

## Interface
- Parameters:
- `WIDTH`, 32: operand and sum width; must be a multiple of `SLICE`.
- `SLICE`, 8: bits added per cycle; `NSLICE = WIDTH/SLICE` (4 by default).
- Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  operands and carry-in are valid.
- `in_ready`  out  1  core can accept operands.
- `a`  in  WIDTH  operand A.
- `b`  in  WIDTH  operand B.
- `cin`  in  1  carry-in.
- `out_valid`  out  1  result is valid.
- `out_ready`  in  1  consumer accepts the result.
- `sum`  out  WIDTH  (a + b + cin) mod 2^WIDTH.
- `cout`  out  1  carry out of bit WIDTH-1.
- `ovf`  out  1  signed overflow: (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]).

## Operation
- FSM states:
- IDLE: `in_ready`=1. On `in_valid`, capture `a`, `b`, `cin`, clear the slice counter and go to BUSY.
- BUSY: each cycle, add slice k of the captured operands plus the running carry, write it into `sum[k*SLICE +: SLICE]`, store the carry and increment k. After slice NSLICE-1, latch `cout` and `ovf` and go to DONE.
- DONE: `out_valid`=1. `sum`, `cout` and `ovf` stay frozen until `out_ready`=1.
  - Handshake without a new input: go to IDLE.
  - `in_valid` in the same cycle: capture the new operands and go straight to BUSY.
- `in_ready` = (state==IDLE) || (state==DONE && out_ready), forced to 0 while `rst_n`=0.
- Captured operands are not affected by input changes after the accept edge.
- Inputs with `in_valid`=0 are ignored in every state. BUSY ignores `in_valid`, since `in_ready`=0.
- Arithmetic is unsigned modulo 2^WIDTH. `ovf` is the two's-complement interpretation only and never affects `sum` or `cout`.

## Timing
- Reset (asynchronous assert, synchronous use after deassert):
  - state=IDLE, slice counter=0.
  - `sum`=0, `cout`=0, `ovf`=0, `out_valid`=0.
  - `in_ready`=0 while reset is asserted; `in_ready`=1 in the first cycle after deassertion.
- Latency:
  - Accept on edge E (`in_valid` && `in_ready`).
  - Slices 0..NSLICE-1 are written on edges E+1..E+NSLICE.
  - `out_valid` is high from edge E+NSLICE, i.e. 4 cycles by default.
- Throughput: with `out_ready` held at 1, one result every NSLICE+1 cycles. The DONE→BUSY path saves the IDLE cycle.
- `sum` during BUSY holds partially updated slices. It is valid only while `out_valid`=1.
- If reset is asserted mid-BUSY or in DONE, the operation is dropped immediately: all outputs go to their reset values and no result is emitted.
- `out_ready` is ignored outside DONE.

## Structure
- Shared package `adder_dut_pkg`:
  - enum `adder_state_e` {IDLE, BUSY, DONE}.
  - Default `WIDTH` and `SLICE` constants.
  - `NSLICE` and counter-width (`$clog2(NSLICE)`) localparams.
- Sub-module `adder_slice`: combinational SLICE-bit adder with ports a, b, cin → s, cout, instantiated once and time-multiplexed by the FSM.
- Core holds the FSM, operand registers, carry register, slice counter and output registers.

## Test plan
- 0xFFFF_FFFF + 0x0000_0001, cin=0, `out_ready`=1 → after 4 cycles sum=0x0000_0000, cout=1, ovf=0; `in_ready` back to 1 on the next cycle.
- 0x7FFF_FFFF + 0x0000_0001, cin=0 → sum=0x8000_0000, cout=0, ovf=1. Also 0x8000_0000 + 0x8000_0000 → sum=0, cout=1, ovf=1.
- 0x1234_5678 + 0x0FED_CBA9, cin=1, `out_ready`=0 for 10 cycles → sum=0x2222_2222, cout=0, ovf=0; outputs stable and `in_ready`=0 throughout; handshake on the 11th cycle.
- Back-to-back: second operand pair presented in the DONE cycle with `out_ready`=1 → accepted on the same edge; second result appears 4 cycles later with no IDLE gap.
- `rst_n` pulsed low at edge E+2 of an operation → `out_valid`, sum, cout and ovf go to 0 immediately; no result is emitted; a fresh operation after release completes correctly.
- Input operands changed on every cycle during BUSY → result matches the operands captured at the accept edge.
